// File: rtl/pmod_ad1_pkg.sv
// Shared types and constants for the Pmod AD1 array capture block.
package pmod_ad1_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned ADC_BITS   = 12;
  localparam int unsigned LEVEL_W    = 8;
  localparam int unsigned LEAD_ZEROS = 4;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    PUBLISH,
    QUIET
  } state_t;

endpackage

// File: rtl/pmod_ad1_array_capture_if.sv
// Pin/bus bundle for pmod_ad1_array_capture: AD1 serial pins plus published sample data.
interface pmod_ad1_array_capture_if
  import pmod_ad1_pkg::*;
#(
  parameter int unsigned N_CH = 5
);
  logic                      en;
  logic [N_CH-1:0]           dDATA;
  logic [N_CH-1:0]           calibrate;
  logic                      CS;
  logic                      SCLK;
  logic [N_CH*ADC_BITS-1:0]  sample;
  logic                      sample_valid;
  logic [N_CH*LEVEL_W-1:0]   level;
  logic [N_CH-1:0]           hit;
  logic                      busy;

  modport master (
    input  en, dDATA, calibrate,
    output CS, SCLK, sample, sample_valid, level, hit, busy
  );

  modport slave (
    output en, dDATA, calibrate,
    input  CS, SCLK, sample, sample_valid, level, hit, busy
  );
endinterface

// File: rtl/ad1_channel_detector.sv
// Per-channel baseline, level, hit and holdoff tracking, updated once per published frame.
// Optional PMOD_AD1_PEAK_HOLD_EN turns level into a decaying peak-hold.
module ad1_channel_detector
  import pmod_ad1_pkg::*;
#(
  parameter int unsigned HIT_THRESH     = 32,
  parameter int unsigned HOLDOFF_FRAMES = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_publish,
  input  logic                i_calibrate,
  input  logic [ADC_BITS-1:0] i_sample,
  output logic [LEVEL_W-1:0]  o_level,
  output logic                o_hit
);
  localparam int unsigned        HO_W    = $clog2(HOLDOFF_FRAMES + 1);
  localparam logic [HO_W-1:0]    HO_INIT = HO_W'(HOLDOFF_FRAMES);
  localparam logic [LEVEL_W-1:0] THRESH  = LEVEL_W'(HIT_THRESH);

  logic [ADC_BITS-1:0]     r_baseline;
  logic [HO_W-1:0]         r_holdoff;
  logic [LEVEL_W-1:0]      r_level;
  logic                    r_hit;
  logic signed [ADC_BITS:0] w_diff;
  logic [ADC_BITS-1:0]     w_mag;
  logic [LEVEL_W-1:0]      w_level_new;
  logic [LEVEL_W-1:0]      w_level_out;
  logic                    w_fire;

  always_comb begin
    w_diff      = $signed({1'b0, i_sample}) - $signed({1'b0, r_baseline});
    w_mag       = w_diff[ADC_BITS] ? ADC_BITS'(-w_diff) : ADC_BITS'(w_diff);
    w_level_new = w_mag[ADC_BITS-1 -: LEVEL_W];
    w_fire      = (w_level_new >= THRESH) && (r_holdoff == '0);
`ifdef PMOD_AD1_PEAK_HOLD_EN
    // Decay the held peak by one per frame, but never below the fresh value.
    w_level_out = (r_level == '0) ? '0 : r_level - LEVEL_W'(1);
    if (w_level_new > w_level_out) w_level_out = w_level_new;
`else
    w_level_out = w_level_new;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_baseline <= '0;
      r_holdoff  <= '0;
      r_level    <= '0;
      r_hit      <= 1'b0;
    end else begin
      r_hit <= 1'b0;
      if (i_publish) begin
        if (i_calibrate) begin
          r_baseline <= i_sample;
          r_level    <= '0;
          r_holdoff  <= '0;
        end else begin
          r_level <= w_level_out;
          if (w_fire) begin
            r_hit     <= 1'b1;
            r_holdoff <= HO_INIT;
          end else if (r_holdoff != '0) begin
            r_holdoff <= r_holdoff - HO_W'(1);
          end
        end
      end
    end
  end

  assign o_level = r_level;
  assign o_hit   = r_hit;
endmodule

// File: rtl/pmod_ad1_array_capture.sv
// Shared CS/SCLK master for N_CH Pmod AD1 lines: frame FSM, synchronisers, shift registers.
// Build option PMOD_AD1_PEAK_HOLD_EN selects peak-hold levels in the channel detectors.
module pmod_ad1_array_capture
  import pmod_ad1_pkg::*;
#(
  parameter int unsigned N_CH           = 5,
  parameter int unsigned SCLK_DIV       = 4000,
  parameter int unsigned QUIET_CYC      = 8000,
  parameter int unsigned HIT_THRESH     = 32,
  parameter int unsigned HOLDOFF_FRAMES = 64
) (
  input  logic                     CLK,
  input  logic                     rst_n,
  pmod_ad1_array_capture_if.master bus
);
  localparam int unsigned CNT_MAX = (SCLK_DIV > QUIET_CYC) ? SCLK_DIV : QUIET_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam int unsigned BIT_W   = $clog2(FRAME_BITS);
  localparam int unsigned SH_W    = FRAME_BITS - LEAD_ZEROS;

  if (SCLK_DIV < 4)                    begin : g_bad_div   $error("SCLK_DIV must be >= 4");      end
  if (QUIET_CYC < 2)                   begin : g_bad_quiet $error("QUIET_CYC must be >= 2");     end
  if ((N_CH < 1) || (N_CH > 16))       begin : g_bad_nch   $error("N_CH must be 1..16");         end
  if (HOLDOFF_FRAMES < 1)              begin : g_bad_ho    $error("HOLDOFF_FRAMES must be >= 1"); end

  logic [1:0]               r_rst_sync;
  logic                     w_rst_n;
  logic [N_CH-1:0]          r_sync1, r_sync2;
  logic [SH_W-1:0]          r_shreg [N_CH];
  state_t                   r_state;
  logic [CNT_W-1:0]         r_cnt;
  logic [BIT_W-1:0]         r_bit;
  logic                     r_phase_hi;
  logic                     r_cs, r_sclk, r_busy, r_valid;
  logic [N_CH*ADC_BITS-1:0] r_sample;
  logic [N_CH*LEVEL_W-1:0]  w_level_all;
  logic [N_CH-1:0]          w_hit_all;
  logic                     w_div_end, w_shift, w_publish;

  // Asynchronous assert, synchronous release.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= '0;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_div_end = (r_cnt == CNT_W'(SCLK_DIV - 1));
  assign w_shift   = (r_state == SHIFT) && r_phase_hi && w_div_end;
  assign w_publish = (r_state == PUBLISH);

  always_ff @(posedge CLK or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bus.dDATA;
      r_sync2 <= r_sync1;
    end
  end

  // Only the low 12 bits are kept; the leading zeros shift straight out.
  always_ff @(posedge CLK or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int i = 0; i < int'(N_CH); i++) r_shreg[i] <= '0;
    end else if (w_shift) begin
      for (int i = 0; i < int'(N_CH); i++) r_shreg[i] <= {r_shreg[i][SH_W-2:0], r_sync2[i]};
    end
  end

  always_ff @(posedge CLK or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_sample <= '0;
    end else if (w_publish) begin
      for (int i = 0; i < int'(N_CH); i++) r_sample[i*ADC_BITS +: ADC_BITS] <= r_shreg[i];
    end
  end

  // Frame sequencer; SCLK toggles every SCLK_DIV cycles while shifting.
  always_ff @(posedge CLK or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_phase_hi <= 1'b1;
      r_cs       <= 1'b1;
      r_sclk     <= 1'b1;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_valid <= w_publish;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (bus.en) begin
            r_cs    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= CS_SETUP;
          end
        end
        CS_SETUP: begin
          if (w_div_end) begin
            r_cnt      <= '0;
            r_bit      <= '0;
            r_sclk     <= 1'b0;
            r_phase_hi <= 1'b0;
            r_state    <= SHIFT;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        SHIFT: begin
          if (w_div_end) begin
            r_cnt <= '0;
            if (!r_phase_hi) begin
              r_sclk     <= 1'b1;
              r_phase_hi <= 1'b1;
            end else if (r_bit == BIT_W'(FRAME_BITS - 1)) begin
              r_cs    <= 1'b1;
              r_state <= PUBLISH;
            end else begin
              r_sclk     <= 1'b0;
              r_phase_hi <= 1'b0;
              r_bit      <= r_bit + BIT_W'(1);
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        PUBLISH: begin
          r_cnt   <= '0;
          r_state <= QUIET;
        end
        QUIET: begin
          if (r_cnt == CNT_W'(QUIET_CYC - 1)) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < int'(N_CH); g++) begin : g_ch
    ad1_channel_detector #(
      .HIT_THRESH     (HIT_THRESH),
      .HOLDOFF_FRAMES (HOLDOFF_FRAMES)
    ) u_det (
      .clk         (CLK),
      .rst_n       (w_rst_n),
      .i_publish   (w_publish),
      .i_calibrate (bus.calibrate[g]),
      .i_sample    (r_shreg[g]),
      .o_level     (w_level_all[g*LEVEL_W +: LEVEL_W]),
      .o_hit       (w_hit_all[g])
    );
  end

  assign bus.CS           = r_cs;
  assign bus.SCLK         = r_sclk;
  assign bus.sample       = r_sample;
  assign bus.sample_valid = r_valid;
  assign bus.level        = w_level_all;
  assign bus.hit          = w_hit_all;
  assign bus.busy         = r_busy;
endmodule

// File: tb/tb_pmod_ad1_array_capture.sv
// Directed bench for pmod_ad1_array_capture with a per-channel AD1 serial model.
module tb_pmod_ad1_array_capture;
  localparam int unsigned N_CH      = 5;
  localparam int unsigned SCLK_DIV  = 4;
  localparam int unsigned QUIET_CYC = 4;
  localparam int          LAT       = 133;   // 2*4*16 + 4 + 1
  localparam int          TMO       = 1000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pmod_ad1_array_capture_if #(.N_CH(N_CH)) bus ();

  pmod_ad1_array_capture #(
    .N_CH           (N_CH),
    .SCLK_DIV       (SCLK_DIV),
    .QUIET_CYC      (QUIET_CYC),
    .HIT_THRESH     (32),
    .HOLDOFF_FRAMES (64)
  ) dut (
    .CLK   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] words [N_CH];
  int          kbit = 0;
  int          frame_bits = 0;
  int          lat, q, nv, ncs, n;
  logic [59:0] s_sample;
  logic [39:0] s_level;
  logic [4:0]  s_hit;
  logic        s_busy, s_valid;

  // AD1 model: next bit MSB-first on each SCLK fall while CS is low.
  always @(negedge bus.SCLK or posedge bus.CS) begin
    if (bus.CS === 1'b1) begin
      frame_bits = kbit;
      kbit       = 0;
      bus.dDATA  = '0;
    end else if (kbit < 16) begin
      for (int i = 0; i < int'(N_CH); i++) bus.dDATA[i] = words[i][15-kbit];
      kbit++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cs_fall(input string tag);
    int c = 0;
    while (bus.CS !== 1'b0 && c < TMO) begin @(posedge clk); #1; c++; end
    if (c >= TMO) check({tag, " cs timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_valid(input string tag, output int cycles);
    cycles = 0;
    while (bus.sample_valid !== 1'b1 && cycles < TMO) begin @(posedge clk); #1; cycles++; end
    if (cycles >= TMO) check({tag, " valid timeout"}, 64'd0, 64'd1);
    s_sample = bus.sample;
    s_level  = bus.level;
    s_hit    = bus.hit;
    s_busy   = bus.busy;
    s_valid  = bus.sample_valid;
  endtask

  task automatic frame(input string tag, output int cycles);
    wait_cs_fall(tag);
    wait_valid(tag, cycles);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " CS"},    64'(bus.CS), 64'd1);
    check({tag, " SCLK"},  64'(bus.SCLK), 64'd1);
    check({tag, " sample"}, 64'(bus.sample), 64'd0);
    check({tag, " level"}, 64'(bus.level), 64'd0);
    check({tag, " hit"},   64'(bus.hit), 64'd0);
    check({tag, " valid"}, 64'(bus.sample_valid), 64'd0);
    check({tag, " busy"},  64'(bus.busy), 64'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.en        = 1'b0;
    bus.calibrate = 5'b00110;
    words[0] = 16'h0ABC; words[1] = 16'h0100; words[2] = 16'h0800;
    words[3] = 16'h0000; words[4] = 16'h0000;
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("idle CS", 64'(bus.CS), 64'd1);
    check("idle busy", 64'(bus.busy), 64'd0);

    // Frame 1: basic capture, ch1/ch2 calibrate, ch0 hits against zero baseline.
    bus.en = 1'b1;
    frame("f1", lat);
    check("f1 latency", 64'(lat), 64'(LAT));
    check("f1 sclk count", 64'(frame_bits), 64'd16);
    check("f1 ch0 sample", 64'(s_sample[11:0]), 64'h0ABC);
    check("f1 sample", 64'(s_sample), 64'h000_000_800_100_ABC);
    check("f1 level", 64'(s_level), 64'h00_00_00_00_AB);
    check("f1 hit", 64'(s_hit), 64'b00001);
    check("f1 busy", 64'(s_busy), 64'd1);
    words[0] = 16'h0000; words[1] = 16'h0400; words[2] = 16'h0900;
    words[3] = 16'h0400; words[4] = 16'h0000;
    bus.calibrate = 5'b01000;
    @(posedge clk); #1;
    check("f1 valid pulse", 64'(bus.sample_valid), 64'd0);
    q = 0;
    while (bus.CS === 1'b1 && q < 100) begin @(posedge clk); #1; q++; end
    check("f1 quiet", 64'(q), 64'(QUIET_CYC));

    // Frame 2: ch2 level 0x10 no hit, ch1 hits, ch3 calibrate wins over hit.
    wait_valid("f2", lat);
    check("f2 sample", 64'(s_sample), 64'h000_400_900_400_000);
    check("f2 level", 64'(s_level), 64'h00_00_10_30_00);
    check("f2 hit", 64'(s_hit), 64'b00010);
    bus.calibrate = 5'b00000;

    // Frames 3..66: ch1 blind during holdoff.
    for (int f = 3; f <= 66; f++) begin
      frame("holdoff", lat);
      check("holdoff hit", 64'(s_hit), 64'd0);
      if (f == 3) check("f3 level", 64'(s_level), 64'h00_00_10_30_00);
    end
    frame("f67", lat);
    check("f67 rehit", 64'(s_hit), 64'b00010);

    // Drop en mid-frame: frame still completes, then idle.
    wait_cs_fall("f68");
    repeat (20) @(posedge clk);
    #1 bus.en = 1'b0;
    wait_valid("f68", lat);
    check("en-drop publish", 64'(s_valid), 64'd1);
    nv = 0; ncs = 0;
    repeat (300) begin
      @(posedge clk); #1;
      if (bus.sample_valid === 1'b1) nv++;
      if (bus.CS !== 1'b1) ncs++;
    end
    check("en-drop extra valids", 64'(nv), 64'd0);
    check("en-drop cs low cycles", 64'(ncs), 64'd0);
    check("en-drop busy", 64'(bus.busy), 64'd0);

    // Reset at bit 7 of a frame, then a clean frame after release.
    bus.en = 1'b1;
    wait_cs_fall("rst frame");
    n = 0;
    while (kbit < 8 && n < TMO) begin @(posedge clk); #1; n++; end
    if (n >= TMO) check("rst bit7 timeout", 64'd0, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("mid-frame reset");
    words[0] = 16'h0123; words[1] = 16'h0456; words[2] = 16'h0789;
    words[3] = 16'h0000; words[4] = 16'h0FFF;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    frame("post-rst", lat);
    check("post-rst latency", 64'(lat), 64'(LAT));
    check("post-rst sample", 64'(s_sample), 64'hFFF_000_789_456_123);
    check("post-rst level", 64'(s_level), 64'hFF_00_78_45_12);
    check("post-rst hit", 64'(s_hit), 64'b10110);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/pmod_ad1_array_capture.md
Name: pmod_ad1_array_capture

Overview:
- Parametrised successor to the per-Pmod AD1 controller/state-machine/informant chain: one serial master drives a shared CS/SCLK for N_CH AD1 data lines (any mix of Pmods).
- Each frame deserialises every channel, publishes 12-bit samples and computes per-channel calibrated sound level.
- Emits single-cycle drum-hit pulses with per-channel holdoff.
- Sits between the Pmod pins and the game/scoring logic, replacing fixed 5-channel wiring and the free-running 12.5 kHz clock module.

Parameters:
- N_CH, 5, number of dDATA lines captured in parallel (1..16)
- SCLK_DIV, 4000, CLK cycles per SCLK half-period (100 MHz -> 12.5 kHz)
- QUIET_CYC, 8000, CLK cycles CS held high between frames (>=2)
- HIT_THRESH, 32, level (8-bit) at or above which a hit fires
- HOLDOFF_FRAMES, 64, frames a channel is blind after a hit (>=1)

Ports:
- CLK  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  run enable; sampled at frame start only
- dDATA  in  N_CH  serial data from AD1 converters (async to CLK)
- calibrate  in  N_CH  per-channel: latch next sample as baseline
- CS  out  1  shared chip select, active low
- SCLK  out  1  shared serial clock, idles high
- sample  out  N_CH*12  last 12-bit conversion per channel, ch i at [12i+11:12i]
- sample_valid  out  1  one-cycle pulse when sample/level update
- level  out  N_CH*8  |sample - baseline|[11:4] per channel
- hit  out  N_CH  one-cycle per-channel hit pulse, coincident with sample_valid
- busy  out  1  high while CS low or in quiet time

Behaviour:
- Reset (async assert, sync deassert internally): CS=1, SCLK=1, sample=0, level=0, hit=0, sample_valid=0, busy=0, baselines=0, holdoff counters=0, FSM=IDLE. Reset mid-frame aborts immediately; no partial sample published.
- dDATA passes through a 2-flop synchroniser per bit; bit timing accounts for the 2-cycle lag (SCLK_DIV>=4 enforced by assertion).
- FSM states: IDLE -> CS_SETUP -> SHIFT -> PUBLISH -> QUIET -> IDLE.
- IDLE: if en=1, CS<=0, go CS_SETUP; else stay, busy=0.
- CS_SETUP: SCLK_DIV cycles, SCLK=1, then SHIFT with bit counter=0.
- SHIFT: 16 bits per frame. Each bit: SCLK low SCLK_DIV cycles, then high SCLK_DIV cycles. Synchronised dDATA shifted MSB-first into a 16-bit shift register per channel, on the CLK cycle SCLK_DIV-1 after SCLK rise. After bit 15 high phase, CS<=1, go PUBLISH.
- PUBLISH (1 cycle): sample[i]<=shreg[i][11:0] (4 leading zeros discarded); sample_valid=1; level/hit/baseline updated per channel as below; go QUIET.
- QUIET: QUIET_CYC cycles, CS=1, SCLK=1, then IDLE. en deasserted mid-frame: frame completes normally.
- Per channel at PUBLISH:
  - calibrate[i]=1: baseline<=new sample, level<=0, hit=0, holdoff<=0. Calibrate wins over a simultaneous hit.
  - Else diff=|sample-baseline| (13-bit signed internally, unsigned 12-bit magnitude); level<=diff[11:4].
  - hit[i]=1 iff level_new>=HIT_THRESH and holdoff==0; then holdoff<=HOLDOFF_FRAMES.
  - Else if holdoff>0, holdoff decrements once per frame (saturates at 0).
- Latency: sample_valid exactly 2*SCLK_DIV*16 + SCLK_DIV + 1 CLK cycles after CS falls. Frame period = that + QUIET_CYC + 1 cycle in IDLE.
- calibrate is level-sensitive, sampled only at PUBLISH; held high, baseline tracks every frame.

Optional Feature:
- Macro PMOD_AD1_PEAK_HOLD_EN.
- Defined: level output is a peak-hold. level<=max(level_prev-1, level_new) each frame, floor 0. Hit decision still uses instantaneous level_new.
- Undefined: level is the instantaneous value. No extra registers are built.

Decomposition:
- Package pmod_ad1_pkg: FSM state enum, constants FRAME_BITS=16, ADC_BITS=12, LEVEL_W=8, LEAD_ZEROS=4.
- Sub-module ad1_channel_detector: baseline, level, holdoff, hit, peak-hold for one channel. Instantiated N_CH times via generate. Top holds FSM, SCLK/CS timing, synchronisers and shift registers.

Test Plan (bench SCLK_DIV=4, QUIET_CYC=4, N_CH=5, ADC model per channel):
- Reset then en=1, ch0 model drives 0x0ABC -> CS low 16 SCLK periods, sample[11:0]=0xABC, sample_valid one pulse, CS high QUIET_CYC cycles.
- calibrate[2]=1 with ch2=0x800; next frame ch2=0x900 -> level[23:16]=0x10, no hit (16<32).
- ch1 baseline 0x100, then 0x400 -> level=0x30, hit[1]=1 once. Then 0x400 for HOLDOFF_FRAMES more frames -> no hit until holdoff expires, then hit again.
- Hit condition and calibrate[3]=1 in same frame -> hit[3]=0, baseline=new sample, level=0.
- rst_n low at bit 7 of a frame -> CS=1, SCLK=1 immediately, all outputs 0. After release, first frame publishes a correct full sample.
- en dropped mid-frame -> frame completes with one sample_valid, then IDLE, busy=0, CS stays high.
